// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the instruction-memory block.
//   ADDR_W      fetch / write address width
//   DATA_W      instruction byte width
//   MEM_DEPTH   number of instruction bytes held
//   COUNT_W     width of the loaded-byte counter (must represent MEM_DEPTH)
//   NOP_OPCODE  default opcode shown when no valid instruction exists
//   imem_state_t  controller states: IDLE, LOAD, RUN
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 256;
    localparam int COUNT_W   = ADDR_W + 1;

    localparam logic [DATA_W-1:0] NOP_OPCODE = 8'h00;

    // Last writable address; reaching it ends a load even without load_last.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } imem_state_t;

endpackage : cpu_pkg

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// 256 x 8 simple dual-port storage, written while a program is loaded and read
// every cycle for instruction fetch. Contents are not reset; the controller
// masks reads beyond the loaded length, so stale bytes never leave the block.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  registered read data (one-cycle latency)
// -----------------------------------------------------------------------------
module imem_ram
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read keeps this mappable onto a block RAM.
    always_ff @(posedge clk) begin
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule : imem_ram

// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
// Instruction memory with a byte-stream program loader. A load_start pulse
// opens a load; bytes are accepted on load_valid && load_ready until a byte
// carrying load_last arrives or the memory is full, after which the cpu is
// released and fetches with one cycle of latency. Fetches at or beyond the
// loaded length return NOP_OP.
//   clk              clock
//   rst              synchronous active-high reset
//   program_counter  fetch address from the cpu
//   op_code          registered instruction byte to the cpu
//   cpu_hold         high while no program is runnable
//   load_start       pulse: begin (or restart) a program load
//   load_data        program byte
//   load_valid       load_data is valid
//   load_ready       block accepts a byte this cycle
//   load_last        accepted byte is the final one of the program
//   loaded_count     number of bytes in the current program (0..256)
// -----------------------------------------------------------------------------
module instr_mem
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] NOP_OP = NOP_OPCODE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  program_counter,
    output logic [DATA_W-1:0]  op_code,
    output logic               cpu_hold,
    input  logic               load_start,
    input  logic [DATA_W-1:0]  load_data,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic               load_last,
    output logic [COUNT_W-1:0] loaded_count
);

    imem_state_t        state_q, state_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               hit_q, hit_d;

    logic               ram_we;
    logic [DATA_W-1:0]  ram_rdata;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    imem_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr_q),
        .wdata (load_data),
        .raddr (program_counter),
        .rdata (ram_rdata)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            waddr_q <= '0;
            count_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            count_q <= count_d;
            hit_q   <= hit_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        count_d    = count_q;
        ram_we     = 1'b0;
        cpu_hold   = 1'b1;
        load_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    waddr_d = '0;
                    count_d = '0;
                end
            end

            LOAD: begin
                load_ready = 1'b1;
                if (load_start) begin
                    // Restart wins over a byte offered in the same cycle.
                    waddr_d = '0;
                    count_d = '0;
                end else if (load_valid) begin
                    ram_we  = 1'b1;
                    count_d = count_q + COUNT_W'(1);
                    // Hold the address at the top rather than wrapping; the
                    // full-memory exit and load_last share one transition.
                    if (waddr_q != LAST_ADDR) begin
                        waddr_d = waddr_q + ADDR_W'(1);
                    end
                    if (load_last || (waddr_q == LAST_ADDR)) begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                cpu_hold = 1'b0;
                if (load_start) begin
                    state_d = LOAD;
                    waddr_d = '0;
                    count_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A fetch is real only in RUN, inside the loaded program, and not in the
    // cycle a new load is requested. The 9-bit compare lets a count of 256
    // cover address 255.
    always_comb begin
        hit_d = (state_q == RUN) && !load_start &&
                ({1'b0, program_counter} < count_q);
    end

    assign op_code      = hit_q ? ram_rdata : NOP_OP;
    assign loaded_count = count_q;

endmodule : instr_mem

// File: tb/tb_instr_mem.sv
module tb_instr_mem;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] program_counter = 8'd0;
    logic [7:0] op_code;
    logic       cpu_hold;
    logic       load_start = 1'b0;
    logic [7:0] load_data = 8'd0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic       load_last = 1'b0;
    logic [8:0] loaded_count;

    int checks   = 0;
    int failures = 0;

    instr_mem #(.NOP_OP(8'h00)) dut (
        .clk             (clk),
        .rst             (rst),
        .program_counter (program_counter),
        .op_code         (op_code),
        .cpu_hold        (cpu_hold),
        .load_start      (load_start),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_last       (load_last),
        .loaded_count    (loaded_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: mode 0 = idle, 1 = loading, 2 = running.
    // The program is a byte array plus its length.
    // ------------------------------------------------------------------
    int         m_mode  = 0;
    int         m_count = 0;
    logic [7:0] m_mem [256];
    logic [7:0] m_op    = 8'h00;
    bit         m_live  = 0;

    always @(posedge clk) begin
        logic [7:0] nxt_op;
        if (rst) begin
            m_mode  = 0;
            m_count = 0;
            m_op    = 8'h00;
            m_live  = 1;
        end else if (m_live) begin
            if (m_mode == 2 && !load_start && int'(program_counter) < m_count)
                nxt_op = m_mem[program_counter];
            else
                nxt_op = 8'h00;
            if (m_mode == 0) begin
                if (load_start) begin m_mode = 1; m_count = 0; end
            end else if (m_mode == 1) begin
                if (load_start) begin
                    m_count = 0;
                end else if (load_valid) begin
                    m_mem[m_count] = load_data;
                    m_count = m_count + 1;
                    if (load_last || m_count == 256) m_mode = 2;
                end
            end else begin
                if (load_start) begin m_mode = 1; m_count = 0; end
            end
            m_op = nxt_op;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (m_live && !rst) begin
            chk("op_code", 32'(op_code), 32'(m_op));
            chk("cpu_hold", 32'(cpu_hold), 32'(m_mode != 2));
            chk("load_ready", 32'(load_ready), 32'(m_mode == 1));
            chk("loaded_count", 32'(loaded_count), 32'(m_count));
            $display("cyc t=%0t mode=%0d pc=%0d op=%02h cnt=%0d", $time, m_mode,
                     program_counter, op_code, loaded_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        int n;
        int sent;

        // Reset and idle.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("idle_op", 32'(op_code), 32'h00);
        chk("idle_hold", 32'(cpu_hold), 32'd1);
        chk("idle_ready", 32'(load_ready), 32'd0);
        chk("idle_count", 32'(loaded_count), 32'd0);

        // Three-byte program.
        pulse_start();
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b1);
        program_counter = 8'd1;
        tick(); tick();
        chk("p3_op_pc1", 32'(op_code), 32'h20);
        chk("p3_hold", 32'(cpu_hold), 32'd0);
        chk("p3_count", 32'(loaded_count), 32'd3);
        program_counter = 8'd3;
        tick(); tick();
        chk("p3_op_pc3", 32'(op_code), 32'h00);
        program_counter = 8'd200;
        tick(); tick();
        chk("p3_op_pc200", 32'(op_code), 32'h00);

        // Full 256-byte program without load_last.
        pulse_start();
        for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
        program_counter = 8'd255;
        tick(); tick();
        chk("full_count", 32'(loaded_count), 32'd256);
        chk("full_hold", 32'(cpu_hold), 32'd0);
        chk("full_op_pc255", 32'(op_code), 32'hFF);

        // Reset mid-load, with load_start asserted alongside reset.
        pulse_start();
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst = 1'b1; load_start = 1'b1;
        tick();
        rst = 1'b0; load_start = 1'b0;
        program_counter = 8'd0;
        tick(); tick();
        chk("rst_count", 32'(loaded_count), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_op", 32'(op_code), 32'h00);
        pulse_start();
        send(8'hAA, 1'b1);
        tick(); tick();
        chk("aa_op", 32'(op_code), 32'hAA);

        // Randomised loads with gaps, restarts and RUN-state restarts.
        for (int it = 0; it < 6; it++) begin
            load_start = 1'b1;
            load_valid = 1'($urandom % 2);
            load_data  = 8'($urandom);
            tick();
            load_start = 1'b0;
            load_valid = 1'b0;
            repeat (4) tick();
            chk("empty_load_ready", 32'(load_ready), 32'd1);
            chk("empty_load_hold", 32'(cpu_hold), 32'd1);
            n = $urandom_range(1, 40);
            sent = 0;
            while (sent < n) begin
                load_valid      = 1'($urandom % 2);
                load_data       = 8'($urandom);
                load_last       = (sent == n - 1);
                program_counter = 8'($urandom);
                tick();
                if (load_valid) sent++;
            end
            load_valid = 1'b0;
            load_last  = 1'b0;
            for (int c = 0; c < 30; c++) begin
                program_counter = 8'($urandom_range(0, n + 5));
                load_valid      = 1'($urandom % 2);
                load_data       = 8'($urandom);
                tick();
            end
            load_valid = 1'b0;
            chk("rand_count", 32'(loaded_count), 32'(n));
            pulse_start();
            chk("restart_hold", 32'(cpu_hold), 32'd1);
            chk("restart_count", 32'(loaded_count), 32'd0);
        end

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_instr_mem

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 Parameter NOP_OP, default 8'h00: opcode returned when no valid instruction is available.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 program_counter  input  8  fetch address driven by the cpu.
REQ-005 op_code  output  8  registered instruction byte to the cpu.
REQ-006 cpu_hold  output  1  high while no program is runnable; the cpu holds its pc at 0.
REQ-007 load_start  input  1  one-cycle pulse that begins a program load.
REQ-008 load_data  input  8  program byte.
REQ-009 load_valid  input  1  load_data is valid.
REQ-010 load_ready  output  1  a byte is accepted when load_valid and load_ready are both high at a posedge.
REQ-011 load_last  input  1  qualifies the accepted byte as the final byte of the program.
REQ-012 loaded_count  output  9  number of bytes in the current program, 0..256.

Function
REQ-013 The FSM SHALL have three states: IDLE, LOAD and RUN.
REQ-014 IDLE: cpu_hold=1, load_ready=0, op_code=NOP_OP; load_start moves the FSM to LOAD.
REQ-015 On entry to LOAD, the write address and loaded_count SHALL clear to 0.
REQ-016 LOAD: cpu_hold=1, load_ready=1, op_code=NOP_OP.
REQ-017 Each accepted byte SHALL be written to mem[waddr], waddr SHALL increment by 1, and loaded_count SHALL increment by 1.
REQ-018 LOAD SHALL exit to RUN on the cycle after an accepted byte that has load_last=1.
REQ-019 LOAD SHALL exit to RUN after the byte accepted at waddr=255; loaded_count is then 256 and waddr does not wrap.
REQ-020 If the byte at waddr=255 also has load_last=1, exactly one transition to RUN SHALL occur.
REQ-021 load_start while in LOAD SHALL restart the load: waddr and loaded_count clear to 0, and any byte offered in that cycle is dropped.
REQ-022 RUN: cpu_hold=0, load_ready=0.
REQ-023 RUN read rule, one-cycle latency: op_code(t+1) = mem[program_counter(t)] if program_counter(t) < loaded_count, otherwise NOP_OP.
REQ-024 load_start in RUN SHALL move the FSM to LOAD; from the next cycle cpu_hold=1 and op_code=NOP_OP.
REQ-025 load_valid outside LOAD SHALL be ignored, and memory SHALL NOT be written.
REQ-026 A load with zero accepted bytes cannot complete; the FSM SHALL remain in LOAD.
REQ-027 loaded_count SHALL be compared at 9-bit width so that 256 covers every address.

Reset
REQ-028 When rst=1 at a posedge, the block SHALL enter IDLE with op_code=NOP_OP, cpu_hold=1, load_ready=0, loaded_count=0 and waddr=0.
REQ-029 Reset in any state, including mid-load, SHALL abort the current operation; reset has priority over load_start.
REQ-030 Memory contents are not reset; because loaded_count=0, no stale byte SHALL reach op_code.

Structure
REQ-031 The shared package cpu_pkg SHALL hold: ADDR_W=8, DATA_W=8, MEM_DEPTH=256, the NOP opcode constant, and the imem_state_t enum {IDLE, LOAD, RUN}.
REQ-032 Storage SHALL be the sub-module imem_ram: 256x8, one synchronous write port, one synchronous read port, no reset.
REQ-033 The FSM, address counter and NOP masking SHALL reside in instr_mem.

Verification
REQ-034 Reset, then hold idle for 10 cycles -> op_code=8'h00, cpu_hold=1, load_ready=0, loaded_count=0.
REQ-035 load_start, then bytes 8'h10, 8'h20, 8'h30 (load_last on 8'h30), then program_counter=1 -> op_code=8'h20 one cycle later; cpu_hold=0; loaded_count=3.
REQ-036 After REQ-035, program_counter=3 and then 200 -> op_code=8'h00 in both cases.
REQ-037 Load 256 bytes of value i with no load_last -> RUN after byte 255; loaded_count=256; program_counter=255 gives op_code=8'hFF.
REQ-038 Assert rst after the 2nd byte of a load, then read program_counter=0 -> IDLE, loaded_count=0, op_code=8'h00; a new load of 8'hAA gives op_code=8'hAA at pc 0.
REQ-039 Toggle load_valid randomly during a load, and pulse load_start in RUN -> only handshaken bytes are stored in order; cpu_hold rises the cycle after the pulse; loaded_count restarts at 0.
